// File: rtl/audio_clkgen_nco.sv
// audio_clkgen_nco: fractional (NCO) audio clock, sample strobe and click-free fade for HDMI audio.
// Latency: clk_audio, sample_stb and audio_out are registered; audio_in is captured on the edge
//    that raises sample_stb. Backpressure: none, the strobe free-runs at the selected rate.
// Ports:
//   clk_pixel   pixel clock, every flop on its rising edge
//   reset       asynchronous, active-high
//   rate_sel    00=48k 01=44.1k 10=32k 11=96k, may change at any time
//   mute        1 = fade to silence and stay there
//   audio_in    CHANNELS packed signed samples, channel 0 in the MSBs
//   clk_audio   square wave whose average frequency is the active sample rate
//   sample_stb  one-cycle pulse in the same cycle clk_audio rises
//   audio_out   attenuated samples, updated together with sample_stb
//   rate_busy   a rate change is pending or being applied
module audio_clkgen_nco #(
   parameter int unsigned CLK_HZ   = 32000000,
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned SAMPLE_W = 16,
   parameter int unsigned ACC_W    = 32
) (
   input  logic                         clk_pixel,
   input  logic                         reset,
   input  logic [1:0]                   rate_sel,
   input  logic                         mute,
   input  logic [CHANNELS*SAMPLE_W-1:0] audio_in,
   output logic                         clk_audio,
   output logic                         sample_stb,
   output logic [CHANNELS*SAMPLE_W-1:0] audio_out,
   output logic                         rate_busy
);

   localparam int unsigned      ATT_W    = $clog2(SAMPLE_W + 1);
   localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(SAMPLE_W);
   localparam logic [ATT_W-1:0] ATT_ONE  = ATT_W'(1);
   localparam logic [ACC_W:0]   MODULUS  = (ACC_W+1)'(CLK_HZ);
   localparam logic [1:0]       RATE_48K = 2'b00;

   typedef enum logic [2:0] {
      ST_MUTED    = 3'd0,
      ST_FADE_IN  = 3'd1,
      ST_PLAY     = 3'd2,
      ST_FADE_OUT = 3'd3,
      ST_SWITCH   = 3'd4
   } state_t;

   state_t                       state_q, state_d;
   logic                         pend_q, pend_d;
   logic [1:0]                   rate_q, rate_d;
   logic [ACC_W-1:0]             acc_q, acc_d;
   logic                         clk_audio_q, clk_audio_d;
   logic                         stb_q, stb_d;
   logic [ATT_W-1:0]             atten_q, atten_d;
   logic [CHANNELS*SAMPLE_W-1:0] out_q, out_d;

   logic                         rate_diff;
   logic [ACC_W:0]               inc;
   logic [ACC_W:0]               sum;
   logic                         wrap;
   logic                         nco_hold;
   logic signed [SAMPLE_W-1:0]   smp_s;
   logic signed [SAMPLE_W-1:0]   shf_s;

   // ------------------------------------------------------------------
   // Fade / rate-switch controller
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      rate_d    = rate_q;
      rate_diff = (rate_sel != rate_q);

      case (state_q)
         ST_PLAY: begin
            if (rate_diff) begin
               state_d = ST_FADE_OUT;
               pend_d  = 1'b1;
            end else if (mute) begin
               state_d = ST_FADE_OUT;
               pend_d  = 1'b0;
            end
         end

         ST_FADE_OUT: begin
            // A rate request arriving during a mute fade is latched here, so a
            // later unmute cannot turn the fade around before the switch happens.
            pend_d = pend_q | rate_diff;
            if (atten_q == ATT_MAX) begin
               state_d = pend_d ? ST_SWITCH : ST_MUTED;
            end else if (!mute && !pend_d) begin
               state_d = ST_FADE_IN;
            end
         end

         ST_MUTED: begin
            if (rate_diff) begin
               state_d = ST_SWITCH;
            end else if (!mute) begin
               state_d = ST_FADE_IN;
            end
         end

         ST_SWITCH: begin
            // rate_sel is read here rather than when the request was seen, so
            // the most recent selection is the one that takes effect.
            rate_d  = rate_sel;
            pend_d  = 1'b0;
            state_d = mute ? ST_MUTED : ST_FADE_IN;
         end

         ST_FADE_IN: begin
            if (rate_diff || mute) begin
               state_d = ST_FADE_OUT;
               pend_d  = rate_diff;
            end else if (atten_q == '0) begin
               state_d = ST_PLAY;
            end
         end

         default: begin
            state_d = ST_MUTED;
            pend_d  = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // NCO: accumulate 2*rate per cycle modulo CLK_HZ; each wrap is one
   // half-period of clk_audio, so the long-run rate is exact.
   // ------------------------------------------------------------------
   always_comb begin
      inc = '0;
      case (rate_q)
         2'b00:   inc = (ACC_W+1)'(96000);
         2'b01:   inc = (ACC_W+1)'(88200);
         2'b10:   inc = (ACC_W+1)'(64000);
         default: inc = (ACC_W+1)'(192000);
      endcase

      // One extra bit so acc + inc can never overflow before the compare.
      sum  = {1'b0, acc_q} + inc;
      wrap = (sum >= MODULUS);

      // The phase is cleared on entry to the switch cycle and held through it,
      // so clk_audio is already low while the new rate is being loaded.
      nco_hold = (state_q == ST_SWITCH) || (state_d == ST_SWITCH);

      if (nco_hold) begin
         acc_d       = '0;
         clk_audio_d = 1'b0;
         stb_d       = 1'b0;
      end else begin
         acc_d       = ACC_W'(wrap ? (sum - MODULUS) : sum);
         clk_audio_d = clk_audio_q ^ wrap;
         stb_d       = wrap & ~clk_audio_q;
      end
   end

   // ------------------------------------------------------------------
   // Sample capture and attenuation. The shift uses the attenuation in
   // force before this strobe; the step towards the fade target follows.
   // ------------------------------------------------------------------
   always_comb begin
      out_d   = out_q;
      atten_d = atten_q;
      smp_s   = '0;
      shf_s   = '0;

      if (stb_d) begin
         for (int c = 0; c < int'(CHANNELS); c++) begin
            smp_s = audio_in[c*SAMPLE_W +: SAMPLE_W];
            shf_s = smp_s >>> atten_q;
            // A full-width arithmetic shift leaves -1 for negative samples;
            // full attenuation must be true silence.
            out_d[c*SAMPLE_W +: SAMPLE_W] = (atten_q == ATT_MAX) ? '0 : shf_s;
         end

         if ((state_q == ST_FADE_OUT) && (atten_q != ATT_MAX)) begin
            atten_d = atten_q + ATT_ONE;
         end else if ((state_q == ST_FADE_IN) && (atten_q != '0)) begin
            atten_d = atten_q - ATT_ONE;
         end
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         state_q     <= ST_MUTED;
         pend_q      <= 1'b0;
         rate_q      <= RATE_48K;
         acc_q       <= '0;
         clk_audio_q <= 1'b0;
         stb_q       <= 1'b0;
         atten_q     <= ATT_MAX;
         out_q       <= '0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         rate_q      <= rate_d;
         acc_q       <= acc_d;
         clk_audio_q <= clk_audio_d;
         stb_q       <= stb_d;
         atten_q     <= atten_d;
         out_q       <= out_d;
      end
   end

   assign clk_audio  = clk_audio_q;
   assign sample_stb = stb_q;
   assign audio_out  = out_q;
   assign rate_busy  = pend_q | (state_q == ST_SWITCH);

endmodule
